// File: rtl/onchip_mem_sched_if.sv
// Bundle between the burst scheduler, its requesters and the auto-incrementing memory macro.
// slave = scheduler side, master = requester/memory side.
interface onchip_mem_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int AW      = 10
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic                      cfg_multi_cycle;
  logic [1:0]                cfg_cycle_count;
  logic [NUM_REQ-1:0]        gnt;
  logic                      beat_ack;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [AW-1:0]             addr_shadow;
  logic [31:0]               beat_total;
  logic                      mem_wr_en;
  logic                      mem_rd_en;
  logic [DATA_W-1:0]         mem_data_in;
  logic [DATA_W-1:0]         mem_data_out;
  logic                      mem_multi_cycle_mode;
  logic [1:0]                mem_cycle_count;

  modport slave (
    input  req, req_wr, req_len, wr_data, cfg_multi_cycle, cfg_cycle_count, mem_data_out,
    output gnt, beat_ack, rd_valid, rd_data, done, busy, addr_shadow, beat_total,
           mem_wr_en, mem_rd_en, mem_data_in, mem_multi_cycle_mode, mem_cycle_count
  );

  modport master (
    output req, req_wr, req_len, wr_data, cfg_multi_cycle, cfg_cycle_count, mem_data_out,
    input  gnt, beat_ack, rd_valid, rd_data, done, busy, addr_shadow, beat_total,
           mem_wr_en, mem_rd_en, mem_data_in, mem_multi_cycle_mode, mem_cycle_count
  );
endinterface

// File: rtl/onchip_mem_sched.sv
// Round-robin burst scheduler for the single-port auto-incrementing on-chip memory.
// Optional ONCHIP_MEM_SCHED_BEAT_CNT_EN adds the 32-bit beat_total counter (tied to 0 otherwise).
module onchip_mem_sched #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int AW      = 10
) (
  input logic               clk,
  input logic               reset,
  onchip_mem_sched_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state_q;
  logic [IW-1:0]     win_q, last_q, pick;
  logic              found;
  logic              mc_q;
  logic [1:0]        cc_q, wait_q;
  logic [LEN_W-1:0]  rem_q, rem_d, pick_len;
  logic [AW-1:0]     shadow_q, shadow_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              fire, step;
  logic [NUM_REQ-1:0] win_oh;

  // Search starts one past the last winner; last_q resets to NUM_REQ-1 so requester 0 leads.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign pick_len = bus.req_len[int'(pick)*LEN_W +: LEN_W];
  assign fire     = (state_q == READ) && (!mc_q || (wait_q == cc_q));
  assign step     = (state_q == WRITE) || fire;
  assign rem_d    = rem_q - LEN_W'(1);
  assign shadow_d = shadow_q + AW'(1);
  assign win_oh   = NUM_REQ'(1) << win_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      mc_q       <= 1'b0;
      cc_q       <= '0;
      wait_q     <= '0;
      rem_q      <= '0;
      shadow_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= fire;
      if (fire) rd_data_q <= bus.mem_data_out;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if (found) begin
            win_q <= pick;
            mc_q  <= bus.cfg_multi_cycle;
            cc_q  <= bus.cfg_cycle_count;
            rem_q <= pick_len;
            if (pick_len == '0)    state_q <= DONE;
            else if (bus.req_wr[pick]) state_q <= WRITE;
            else                   state_q <= READ;
          end
        end
        WRITE: begin
          rem_q    <= rem_d;
          shadow_q <= shadow_d;
          if (rem_q == LEN_W'(1)) state_q <= DONE;
        end
        READ: begin
          // Wait counter mirrors the memory's own 0..C sequence so fires line up.
          wait_q <= fire ? 2'd0 : wait_q + 2'd1;
          if (fire) begin
            rem_q    <= rem_d;
            shadow_q <= shadow_d;
            if (rem_q == LEN_W'(1)) state_q <= DONE;
          end
        end
        DONE: begin
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ONCHIP_MEM_SCHED_BEAT_CNT_EN
  logic [31:0] beat_total_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     beat_total_q <= '0;
    else if (step) beat_total_q <= beat_total_q + 32'd1;
  end

  assign bus.beat_total = beat_total_q;
`else
  assign bus.beat_total = 32'd0;
`endif

  assign bus.gnt         = ((state_q == WRITE) || (state_q == READ)) ? win_oh : '0;
  assign bus.done        = (state_q == DONE) ? win_oh : '0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.beat_ack    = (state_q == WRITE);
  assign bus.mem_wr_en   = (state_q == WRITE);
  assign bus.mem_rd_en   = (state_q == READ);
  assign bus.mem_data_in = (state_q == WRITE) ? bus.wr_data[int'(win_q)*DATA_W +: DATA_W] : '0;
  assign bus.mem_multi_cycle_mode = (state_q == READ) && mc_q;
  assign bus.mem_cycle_count      = (state_q == READ) ? cc_q : 2'd0;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.addr_shadow = shadow_q;
endmodule

// File: tb/tb_onchip_mem_sched.sv
// Scoreboard bench for onchip_mem_sched: burst-level reference model (round-robin order,
// flat memory image, pointer) predicts read data, done order, strobe counts and pointer.
`timescale 1ns/1ps
module tb_onchip_mem_sched;
  localparam int NR = 2, DW = 16, LW = 10, AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  onchip_mem_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW), .AW(AW)) bus ();
  onchip_mem_sched #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory macro model ----------------
  logic [DW-1:0] mem_arr [0:1023];
  logic [AW-1:0] mem_ptr;
  logic [1:0]    mem_w;
  logic          mem_init = 1'b0;
  assign bus.mem_data_out = mem_arr[mem_ptr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ptr <= '0;
      mem_w   <= '0;
      if (!mem_init) begin
        for (int k = 0; k < 1024; k++) mem_arr[k] <= '0;
        mem_init <= 1'b1;
      end
    end else if (bus.mem_wr_en) begin
      mem_arr[mem_ptr] <= bus.mem_data_in;
      mem_ptr <= mem_ptr + 1'b1;
    end else if (bus.mem_rd_en) begin
      if (!bus.mem_multi_cycle_mode || mem_w == bus.mem_cycle_count) begin
        mem_ptr <= mem_ptr + 1'b1;
        mem_w   <= '0;
      end else mem_w <= mem_w + 1'b1;
    end else mem_w <= '0;
  end

  // ---------------- write-data supply per requester ----------------
  logic [DW-1:0] wbuf [NR][0:2047];
  int wrd [NR];
  int wwr [NR];

  function automatic void refresh_wd();
    for (int i = 0; i < NR; i++)
      bus.wr_data[i*DW +: DW] = (wrd[i] < wwr[i]) ? wbuf[i][wrd[i] % 2048] : '0;
  endfunction

  initial begin
    refresh_wd();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        for (int i = 0; i < NR; i++) wrd[i] = wwr[i];
      end else if (bus.beat_ack) begin
        for (int i = 0; i < NR; i++) if (bus.gnt[i]) wrd[i] = wrd[i] + 1;
      end
      #1 refresh_wd();
    end
  end

  // ---------------- scoreboard queues and monitor ----------------
  logic [DW-1:0] exp_rd_q [$];
  int            exp_done_q [$];
  bit            exp_rv_q [$];
  int            wr_beats = 0;
  int            rd_cycles = 0;
  logic          cur_mc = 1'b0;
  logic [1:0]    cur_c = 2'd0;

  initial begin
    logic prev_done;
    int d;
    bit v;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
      end else begin
        if (bus.mem_wr_en) wr_beats++;
        if (bus.mem_rd_en) begin
          rd_cycles++;
          chk("mem_mc_mode", bus.mem_multi_cycle_mode, cur_mc);
          chk("mem_cycle_count", bus.mem_cycle_count, cur_c);
        end else begin
          chk("mem_mode_idle", {bus.mem_multi_cycle_mode, bus.mem_cycle_count}, 0);
        end
        chk("beat_ack_vs_wr_en", bus.beat_ack, bus.mem_wr_en);
        if (bus.busy) chk("gnt_onehot", ($countones(bus.gnt) <= 1), 1);
        if (prev_done) chk("idle_gap_after_done", bus.busy, 0);
        if (bus.rd_valid) begin
          if (exp_rd_q.size() == 0) chk("rd_valid_unexpected", bus.rd_valid, 0);
          else chk("rd_data", bus.rd_data, exp_rd_q.pop_front());
        end
        if (bus.done != '0) begin
          if (exp_done_q.size() == 0) chk("done_unexpected", bus.done, 0);
          else begin
            d = exp_done_q.pop_front();
            v = exp_rv_q.pop_front();
            chk("done_order", bus.done, 64'(1) << d);
            chk("last_rd_with_done", bus.rd_valid, v);
          end
        end
        prev_done = (bus.done != '0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:1023];
  int ref_ptr = 0;
  int ref_last = NR - 1;
  int ref_beats = 0;
  int wbase = -1;
  int s_len [NR];
  int s_cnt [NR];

  function automatic int rr_pick(input logic [NR-1:0] act);
    for (int k = 1; k <= NR; k++) begin
      int idx = (ref_last + k) % NR;
      if (act[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    exp_rd_q.delete();
    exp_done_q.delete();
    exp_rv_q.delete();
    ref_ptr = 0;
    ref_last = NR - 1;
    ref_beats = 0;
    #1;
    chk("reset_ctrl", {bus.gnt, bus.done, bus.beat_ack, bus.rd_valid, bus.busy,
                       bus.mem_wr_en, bus.mem_rd_en, bus.mem_multi_cycle_mode}, 0);
    chk("reset_data", {bus.mem_cycle_count, bus.mem_data_in, bus.rd_data, bus.addr_shadow}, 0);
    chk("reset_beat_total", bus.beat_total, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one set of requests: requester i asks s_cnt[i] bursts of s_len[i] beats.
  task automatic run_set(input logic [NR-1:0] mask, input logic [NR-1:0] wr,
                         input logic mc, input logic [1:0] c);
    int n [NR];
    int exp_wr, exp_rd, wb0, rc0, lat, first_done, w, single, exp_lat;
    logic [NR-1:0] act;
    logic [DW-1:0] word;
    exp_wr = 0; exp_rd = 0; first_done = -1; single = -1;
    for (int i = 0; i < NR; i++) n[i] = mask[i] ? s_cnt[i] : 0;
    if ($countones(mask) == 1) for (int i = 0; i < NR; i++) if (mask[i] && s_cnt[i] == 1) single = i;
    act = mask;
    while (act != '0) begin
      w = rr_pick(act);
      ref_last = w;
      n[w]--;
      if (n[w] == 0) act[w] = 1'b0;
      for (int b = 0; b < s_len[w]; b++) begin
        if (wr[w]) begin
          if (wbase >= 0) begin word = DW'(wbase); wbase++; end
          else word = DW'($urandom);
          wbuf[w][wwr[w] % 2048] = word;
          wwr[w]++;
          ref_mem[ref_ptr] = word;
        end else begin
          exp_rd_q.push_back(ref_mem[ref_ptr]);
        end
        ref_ptr = (ref_ptr + 1) % 1024;
        ref_beats++;
      end
      if (wr[w]) exp_wr += s_len[w];
      else exp_rd += s_len[w] * (mc ? int'(c) + 1 : 1);
      exp_done_q.push_back(w);
      exp_rv_q.push_back(!wr[w] && s_len[w] > 0);
    end
    for (int i = 0; i < NR; i++) n[i] = mask[i] ? s_cnt[i] : 0;
    @(negedge clk);
    wb0 = wr_beats; rc0 = rd_cycles;
    cur_mc = mc; cur_c = c;
    bus.cfg_multi_cycle = mc;
    bus.cfg_cycle_count = c;
    bus.req_wr = wr;
    for (int i = 0; i < NR; i++) bus.req_len[i*LW +: LW] = LW'(s_len[i]);
    bus.req = mask;
    lat = 0;
    while (bus.req != '0 && lat < 20000) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && single >= 0 && s_len[single] > 0) chk("grant_latency", bus.gnt, 64'(1) << single);
      for (int i = 0; i < NR; i++) if (bus.done[i]) begin
        if (first_done < 0) first_done = lat;
        n[i]--;
        if (n[i] <= 0) bus.req[i] = 1'b0;
      end
    end
    if (bus.req != '0) begin
      chk("set_timeout", bus.req, 0);
      bus.req = '0;
    end
    repeat (2) @(negedge clk);
    if (single >= 0) begin
      exp_lat = bus.req_wr[single] ? s_len[single] + 1
                                   : s_len[single] * (mc ? int'(c) + 1 : 1) + 1;
      chk("done_latency", 64'(first_done), 64'(exp_lat));
    end
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    chk("wr_strobe_cycles", 64'(wr_beats - wb0), 64'(exp_wr));
    chk("rd_strobe_cycles", 64'(rd_cycles - rc0), 64'(exp_rd));
    chk("addr_shadow", bus.addr_shadow, 64'(ref_ptr));
    chk("busy_after_set", bus.busy, 0);
`ifdef ONCHIP_MEM_SCHED_BEAT_CNT_EN
    chk("beat_total", bus.beat_total, 64'(ref_beats));
`else
    chk("beat_total", bus.beat_total, 0);
`endif
  endtask

  initial begin
    int nb, lat;
    for (int k = 0; k < 1024; k++) ref_mem[k] = '0;
    bus.req = '0; bus.req_wr = '0; bus.req_len = '0;
    bus.cfg_multi_cycle = 1'b0; bus.cfg_cycle_count = 2'd0;
    repeat (3) @(negedge clk);
    do_reset();

    // Write 0xA001..0xA004 from requester 0, then read it back after a reset.
    wbase = 16'hA001;
    s_len[0] = 4; s_cnt[0] = 1; s_len[1] = 0; s_cnt[1] = 0;
    run_set(2'b01, 2'b01, 1'b0, 2'd0);
    chk("shadow_after_write4", bus.addr_shadow, 4);
    wbase = -1;
    do_reset();
    run_set(2'b01, 2'b00, 1'b0, 2'd0);
    s_len[0] = 3;
    run_set(2'b01, 2'b00, 1'b1, 2'd2);

    // Both requesters held, two L=2 writes each: alternating grants.
    do_reset();
    s_len[0] = 2; s_cnt[0] = 2; s_len[1] = 2; s_cnt[1] = 2;
    run_set(2'b11, 2'b11, 1'b0, 2'd0);

    // Zero-length burst on requester 1.
    s_len[1] = 0; s_cnt[1] = 1; s_cnt[0] = 0;
    run_set(2'b10, 2'b10, 1'b0, 2'd0);

    // Reset after 3 beats of an 8-beat write: no done, outputs cleared.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      wbuf[0][wwr[0] % 2048] = DW'(16'hB000 + k);
      wwr[0]++;
    end
    @(negedge clk);
    bus.req_wr = 2'b01;
    bus.req_len[0 +: LW] = LW'(8);
    bus.req = 2'b01;
    nb = 0; lat = 0;
    while (nb < 3 && lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.beat_ack) nb++;
    end
    chk("abort_beats_seen", 64'(nb), 3);
    for (int k = 0; k < 3; k++) ref_mem[k] = DW'(16'hB000 + k);
    do_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_activity", {bus.busy, bus.gnt, bus.done}, 0);
    s_len[0] = 5; s_cnt[0] = 1; s_cnt[1] = 0;
    run_set(2'b01, 2'b00, 1'b0, 2'd0);

    // Randomized sets.
    for (int t = 0; t < 24; t++) begin
      logic [NR-1:0] mask, wr;
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      wr   = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        s_len[i] = $urandom_range(0, 12);
        s_cnt[i] = $urandom_range(1, 3);
      end
      run_set(mask, wr, 1'($urandom), 2'($urandom));
    end

    // Pointer wrap: 1023 + 7 write beats after reset.
    do_reset();
    s_len[0] = 1023; s_cnt[0] = 1; s_cnt[1] = 0;
    run_set(2'b01, 2'b01, 1'b0, 2'd0);
    s_len[0] = 7;
    run_set(2'b01, 2'b01, 1'b0, 2'd0);
    chk("wrap_shadow", bus.addr_shadow, 6);
`ifdef ONCHIP_MEM_SCHED_BEAT_CNT_EN
    chk("wrap_beat_total", bus.beat_total, 1030);
`else
    chk("wrap_beat_total", bus.beat_total, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
